// File: rtl/term_ctrl.sv
// Text-terminal sequencer: decodes PS/2 set-2 scan codes into character writes,
// owns the cursor and scroll base, and clears the recycled row after a scroll.
module term_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic       wr_en,
    output logic [6:0] wr_x,
    output logic [4:0] wr_y,
    output logic [7:0] wr_data,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y,
    output logic [4:0] scroll_base,
    output logic       busy,
    output logic       overrun,
    output logic       dbg_state
);

    // Handshake: key_valid is a one-cycle strobe with no back-pressure; a code that
    // arrives while the one-deep pending buffer is full is dropped and flagged on overrun.

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    state_t     state, n_state;
    logic       shift, n_shift;
    logic       brk, n_brk;
    logic       ext, n_ext;
    logic       pend_valid, n_pend_valid;
    logic [7:0] pend_data, n_pend_data;
    logic [6:0] n_cur_x;
    logic [4:0] n_cur_y, n_scroll_base;
    logic [4:0] clr_row, n_clr_row;
    logic [6:0] clr_x, n_clr_x;
    logic       n_wr_en, n_overrun;
    logic [6:0] n_wr_x;
    logic [4:0] n_wr_y;
    logic [7:0] n_wr_data;
    logic       proc, newline;
    logic [7:0] code, asc;

    function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] y);
        logic [5:0] s;
        s = {1'b0, base} + {1'b0, y};
        if (s >= 6'(ROWS)) s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    // Returns 0 for codes that are not printable.
    function automatic logic [7:0] to_ascii(input logic [7:0] sc, input logic up);
        logic [7:0] a;
        case (sc)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39; 8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        if (up && a >= 8'h61) a = a - 8'h20;
        return a;
    endfunction

    always_comb begin
        n_state       = state;
        n_shift       = shift;
        n_brk         = brk;
        n_ext         = ext;
        n_pend_valid  = pend_valid;
        n_pend_data   = pend_data;
        n_cur_x       = cur_x;
        n_cur_y       = cur_y;
        n_scroll_base = scroll_base;
        n_clr_row     = clr_row;
        n_clr_x       = clr_x;
        n_wr_en       = 1'b0;
        n_wr_x        = wr_x;
        n_wr_y        = wr_y;
        n_wr_data     = wr_data;
        n_overrun     = 1'b0;
        proc          = 1'b0;
        newline       = 1'b0;
        code          = 8'h00;

        if (state == S_IDLE) begin
            if (pend_valid) begin
                proc         = 1'b1;
                code         = pend_data;
                n_pend_valid = key_valid;
                if (key_valid) n_pend_data = key_data;
            end else if (key_valid) begin
                proc = 1'b1;
                code = key_data;
            end
        end
        asc = to_ascii(code, shift);

        case (state)
            S_IDLE: begin
                if (proc) begin
                    if (code == 8'hF0) begin
                        n_brk = 1'b1;
                    end else if (code == 8'hE0) begin
                        n_ext = 1'b1;
                    end else if (brk) begin
                        n_brk = 1'b0;
                        n_ext = 1'b0;
                        if (code == 8'h12 || code == 8'h59) n_shift = 1'b0;
                    end else if (ext) begin
                        n_ext = 1'b0;
                    end else if (code == 8'h12 || code == 8'h59) begin
                        n_shift = 1'b1;
                    end else if (code == 8'h5A) begin
                        newline = 1'b1;
                    end else if (code == 8'h66) begin
                        if (cur_x != 7'd0) begin
                            n_cur_x   = cur_x - 7'd1;
                            n_wr_en   = 1'b1;
                            n_wr_x    = cur_x - 7'd1;
                            n_wr_y    = phys_row(scroll_base, cur_y);
                            n_wr_data = 8'h20;
                        end else if (cur_y != 5'd0) begin
                            n_cur_x   = X_MAX;
                            n_cur_y   = cur_y - 5'd1;
                            n_wr_en   = 1'b1;
                            n_wr_x    = X_MAX;
                            n_wr_y    = phys_row(scroll_base, cur_y - 5'd1);
                            n_wr_data = 8'h20;
                        end
                    end else if (asc != 8'h00) begin
                        n_wr_en   = 1'b1;
                        n_wr_x    = cur_x;
                        n_wr_y    = phys_row(scroll_base, cur_y);
                        n_wr_data = asc;
                        if (cur_x == X_MAX) newline = 1'b1;
                        else n_cur_x = cur_x + 7'd1;
                    end
                end
                // Scrolling recycles the old top row as the new bottom row.
                if (newline) begin
                    n_cur_x = 7'd0;
                    if (cur_y != Y_MAX) begin
                        n_cur_y = cur_y + 5'd1;
                    end else begin
                        n_scroll_base = (scroll_base == Y_MAX) ? 5'd0 : scroll_base + 5'd1;
                        n_clr_row     = scroll_base;
                        n_clr_x       = 7'd0;
                        n_state       = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                n_wr_en   = 1'b1;
                n_wr_x    = clr_x;
                n_wr_y    = clr_row;
                n_wr_data = 8'h20;
                if (clr_x == X_MAX) n_state = S_IDLE;
                else n_clr_x = clr_x + 7'd1;
                if (key_valid) begin
                    if (pend_valid) begin
                        n_overrun = 1'b1;
                    end else begin
                        n_pend_valid = 1'b1;
                        n_pend_data  = key_data;
                    end
                end
            end
            default: n_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shift       <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            pend_valid  <= 1'b0;
            pend_data   <= 8'h00;
            cur_x       <= 7'd0;
            cur_y       <= 5'd0;
            scroll_base <= 5'd0;
            clr_row     <= 5'd0;
            clr_x       <= 7'd0;
            wr_en       <= 1'b0;
            wr_x        <= 7'd0;
            wr_y        <= 5'd0;
            wr_data     <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            state       <= n_state;
            shift       <= n_shift;
            brk         <= n_brk;
            ext         <= n_ext;
            pend_valid  <= n_pend_valid;
            pend_data   <= n_pend_data;
            cur_x       <= n_cur_x;
            cur_y       <= n_cur_y;
            scroll_base <= n_scroll_base;
            clr_row     <= n_clr_row;
            clr_x       <= n_clr_x;
            wr_en       <= n_wr_en;
            wr_x        <= n_wr_x;
            wr_y        <= n_wr_y;
            wr_data     <= n_wr_data;
            overrun     <= n_overrun;
        end
    end

    assign busy      = (state == S_CLEAR);
    assign dbg_state = (state == S_CLEAR);

endmodule
